// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU and the pipeline control unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_MULU = 4'b1010;
   localparam logic [3:0] ALU_DIVU = 4'b1011;
   localparam logic [3:0] ALU_NOR  = 4'b1100;

   localparam logic MDU_MUL = 1'b0;
   localparam logic MDU_DIV = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_t;

   // Divide by zero short-circuits to a single-cycle result.
   function automatic logic needs_iter(input logic [3:0] op, input logic divisor_zero);
      return (op == ALU_MULU) || ((op == ALU_DIVU) && !divisor_zero);
   endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Latency: WIDTH cycles after start; done pulses with hi/lo valid in the same cycle.
// Backpressure: none; caller must capture hi/lo while done is high.
module alu_mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic             busy_q, busy_d;
   logic             op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_diff;

   // hi holds the partial product / remainder, lo the multiplier / quotient bits.
   always_comb begin
      add_sum   = {1'b0, hi_q} + {1'b0, opb_q};
      rem_shift = {hi_q, lo_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opb_q};
      busy_d    = busy_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      opb_d     = opb_q;
      done      = 1'b0;
      if (start) begin
         busy_d = 1'b1;
         op_d   = op;
         cnt_d  = '0;
         hi_d   = '0;
         lo_d   = opa;
         opb_d  = opb;
      end else if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
         if (op_q == MDU_MUL) begin
            if (lo_q[0]) {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
            else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
         end else if (!rem_diff[WIDTH]) begin
            hi_d = rem_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = rem_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            done   = 1'b1;
            busy_d = 1'b0;
         end
      end
   end

   assign hi = hi_d;
   assign lo = lo_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         op_q   <= MDU_MUL;
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         opb_q  <= '0;
      end else begin
         busy_q <= busy_d;
         op_q   <= op_d;
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opb_q  <= opb_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides plus iterative MULU/DIVU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for MULU/DIVU.
// Backpressure: result held while outValid && !outReady; inReady low while busy or held.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic [3:0]       aluCtr,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] aluRes,
   output logic [WIDTH-1:0] aluResHi,
   output logic             zero,
   output logic             overflow,
   output logic             divZero
);

   alu_state_t       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;

   logic [WIDTH-1:0]   sum, diff, sc_res, sc_hi;
   logic [SHAMT_W-1:0] shamt;
   logic               sc_ovf, sc_dz;
   logic               accept, mdu_start, mdu_op, mdu_done;
   logic [WIDTH-1:0]   mdu_hi, mdu_lo;

   always_comb begin : single_cycle_alu
      sum    = input1 + input2;
      diff   = input1 - input2;
      shamt  = input2[SHAMT_W-1:0];
      sc_res = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_dz  = 1'b0;
      case (aluCtr)
         ALU_AND:  sc_res = input1 & input2;
         ALU_OR:   sc_res = input1 | input2;
         ALU_ADD: begin
            sc_res = sum;
            sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
         end
         ALU_XOR:  sc_res = input1 ^ input2;
         ALU_SLL:  sc_res = input1 << shamt;
         ALU_SRL:  sc_res = input1 >> shamt;
         ALU_SUB: begin
            sc_res = diff;
            sc_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
         end
         ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
         ALU_SRA:  sc_res = $unsigned($signed(input1) >>> shamt);
         ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, input1 < input2};
         ALU_NOR:  sc_res = ~(input1 | input2);
         // Only reached with a zero divisor; real divides go iterative.
         ALU_DIVU: begin
            sc_res = '1;
            sc_hi  = input1;
            sc_dz  = 1'b1;
         end
         default:  sc_res = '0;
      endcase
   end

   assign inReady = (state_q == IDLE) && (!out_valid_q || outReady);
   assign accept  = inValid && inReady;
   assign mdu_op  = (aluCtr == ALU_DIVU) ? MDU_DIV : MDU_MUL;

   always_comb begin : control
      state_d     = state_q;
      out_valid_d = out_valid_q;
      res_d       = res_q;
      res_hi_d    = res_hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      dz_d        = dz_q;
      mdu_start   = 1'b0;
      if (out_valid_q && outReady) out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (needs_iter(aluCtr, input2 == '0)) begin
                  mdu_start = 1'b1;
                  state_d   = BUSY;
               end else begin
                  res_d       = sc_res;
                  res_hi_d    = sc_hi;
                  zero_d      = (sc_res == '0);
                  ovf_d       = sc_ovf;
                  dz_d        = sc_dz;
                  out_valid_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (mdu_done) begin
               res_d       = mdu_lo;
               res_hi_d    = mdu_hi;
               zero_d      = (mdu_lo == '0);
               ovf_d       = 1'b0;
               dz_d        = 1'b0;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   alu_mdu_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mdu (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mdu_start),
      .op      (mdu_op),
      .opa     (input1),
      .opb     (input2),
      .done    (mdu_done),
      .hi      (mdu_hi),
      .lo      (mdu_lo)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         res_hi_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         res_hi_q    <= res_hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         dz_q        <= dz_d;
      end
   end

   assign outValid = out_valid_q;
   assign aluRes   = res_q;
   assign aluResHi = res_hi_q;
   assign zero     = zero_q;
   assign overflow = ovf_q;
   assign divZero  = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops and compares.
module tb_alu_seq;
   localparam int W = 32;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic        z;
      logic        ov;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk, reset_n, inValid, inReady, outValid, outReady;
   logic [31:0] input1, input2, aluRes, aluResHi;
   logic [3:0]  aluCtr;
   logic        zero, overflow, divZero;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   seen = 0;
   bit   rand_rdy = 0;

   alu_seq #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) dut (
      .clk(clk), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
      .input1(input1), .input2(input2), .aluCtr(aluCtr), .outValid(outValid),
      .outReady(outReady), .aluRes(aluRes), .aluResHi(aluResHi), .zero(zero),
      .overflow(overflow), .divZero(divZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model from plain arithmetic on the op definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb_, s;
      logic [63:0] p;
      int          sh;
      e   = '{default: 0};
      e.lat = 1;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      sh  = int'(b % 32);
      case (op)
         4'd0:  e.res = a & b;
         4'd1:  e.res = a | b;
         4'd2: begin
            e.res = a + b;
            s = sa + sb_;
            e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd3:  e.res = a ^ b;
         4'd4:  e.res = a << sh;
         4'd5:  e.res = a >> sh;
         4'd6: begin
            e.res = a - b;
            s = sa - sb_;
            e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd7:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
         4'd8: begin
            e.res = a >> sh;
            if (a >= 32'h8000_0000) e.res = e.res | ~(32'hFFFF_FFFF >> sh);
         end
         4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
         4'd10: begin
            p = 64'(a) * 64'(b);
            e.res = p[31:0];
            e.hi  = p[63:32];
            e.lat = W + 1;
         end
         4'd11: begin
            if (b == 0) begin
               e.res = 32'hFFFF_FFFF;
               e.hi  = a;
               e.dz  = 1'b1;
            end else begin
               e.res = a / b;
               e.hi  = a % b;
               e.lat = W + 1;
            end
         end
         4'd12: e.res = ~(a | b);
         default: e.res = 32'd0;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit rdy = 1'b1);
      exp_t e;
      int   n;
      @(negedge clk);
      inValid = 1'b1;
      aluCtr  = op;
      input1  = a;
      input2  = b;
      if (!rand_rdy) outReady = rdy;
      #1;
      n = 0;
      while (!inReady && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!inReady) begin
         chk("accept_timeout", 64'(inReady), 64'd1);
         inValid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         e = model(op, a, b);
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      inValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (reset_n && outValid) begin
            if (sb.size() == 0) begin
               chk("spurious_outValid", 64'(outValid), 64'd0);
            end else begin
               mon_e = sb[0];
               if (!seen) begin
                  chk("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
                  seen = 1'b1;
               end
               chk("aluRes", 64'(aluRes), 64'(mon_e.res));
               chk("aluResHi", 64'(aluResHi), 64'(mon_e.hi));
               chk("zero", 64'(zero), 64'(mon_e.z));
               chk("overflow", 64'(overflow), 64'(mon_e.ov));
               chk("divZero", 64'(divZero), 64'(mon_e.dz));
               if (outReady) begin
                  void'(sb.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) if (rand_rdy) outReady = ($urandom_range(0, 3) != 0);

   initial begin : driver
      logic [3:0]  op;
      logic [31:0] a, b;
      reset_n  = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      input1   = '0;
      input2   = '0;
      aluCtr   = '0;
      #12;
      chk("rst_outValid", 64'(outValid), 64'd0);
      chk("rst_aluRes", 64'(aluRes), 64'd0);
      chk("rst_aluResHi", 64'(aluResHi), 64'd0);
      chk("rst_flags", 64'({zero, overflow, divZero}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("inReady_after_reset", 64'(inReady), 64'd1);

      issue(4'd0, 32'd255, 32'd170);
      issue(4'd1, 32'd255, 32'd170);
      issue(4'd6, 32'd1, 32'd1);
      issue(4'd12, 32'd0, 32'd1);
      issue(4'd7, 32'h8000_0000, 32'd1);
      issue(4'd9, 32'h8000_0000, 32'd1);
      issue(4'd2, 32'h7FFF_FFFF, 32'd1);
      issue(4'd8, 32'h8000_0000, 32'd4);
      issue(4'd11, 32'd5, 32'd0);
      issue(4'd13, 32'd3, 32'd4);
      idle();
      drain();

      issue(4'd10, 32'hFFFF_FFFF, 32'd2);
      for (int i = 0; i < W - 1; i++) begin
         @(negedge clk);
         inValid = 1'b0;
         #1;
         chk("inReady_busy", 64'(inReady), 64'd0);
      end
      drain();
      issue(4'd11, 32'd100, 32'd7);
      idle();
      drain();

      // Backpressure then simultaneous pop and accept.
      issue(4'd2, 32'd10, 32'd20, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         inValid = 1'b0;
         #1;
         chk("inReady_hold", 64'(inReady), 64'd0);
         chk("outValid_hold", 64'(outValid), 64'd1);
      end
      issue(4'd2, 32'd2, 32'd3, 1'b1);
      idle();
      drain();

      // Async reset in the middle of a multiply.
      issue(4'd10, $urandom, $urandom);
      idle();
      repeat (9) @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_outValid", 64'(outValid), 64'd0);
      chk("midrst_aluRes", 64'(aluRes), 64'd0);
      chk("midrst_aluResHi", 64'(aluResHi), 64'd0);
      chk("midrst_flags", 64'({zero, overflow, divZero}), 64'd0);
      sb.delete();
      seen = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("inReady_after_midrst", 64'(inReady), 64'd1);
      issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      idle();
      drain();

      // Back-to-back single-cycle stream.
      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(0, 9));
         issue(op, $urandom, $urandom);
      end
      idle();
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         issue(op, a, b);
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle();
      rand_rdy = 1'b0;
      outReady = 1'b1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle 32-bit ALU.
- Adds operations beyond the existing AND/OR/ADD/SUB/SLT/NOR set: XOR, shifts, unsigned compare, overflow flag, and an iterative unsigned multiply/divide.
- Valid/ready handshakes on both sides, so it can sit in the EX stage of a stallable pipeline.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
SHAMT_W, 5, shift-amount bits taken from input2 LSBs (log2 WIDTH)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
inValid  in  1  operation request
inReady  out  1  block can accept a request this cycle
input1  in  WIDTH  operand A
input2  in  WIDTH  operand B
aluCtr  in  4  operation select
outValid  out  1  result registers hold a valid result
outReady  in  1  consumer accepts result this cycle
aluRes  out  WIDTH  result (product low / quotient)
aluResHi  out  WIDTH  product high / remainder; 0 for single-cycle ops
zero  out  1  aluRes == 0
overflow  out  1  signed overflow on ADD/SUB; 0 otherwise
divZero  out  1  DIVU with input2 == 0

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1010 MULU, 1011 DIVU, 1100 NOR.
- Unused codes: single-cycle op, aluRes = 0, zero = 1.
- Accept rule: a request is accepted on a rising edge where inValid && inReady.
- inReady = (state == IDLE) && (!outValid || outReady). A simultaneous result pop and new accept is allowed, giving full throughput for single-cycle ops.
- States:
  - IDLE: accept. Single-cycle op: result registered at the accept edge; outValid = 1 next cycle (latency 1); stay IDLE. MULU/DIVU: latch operands, clear counter, go to BUSY.
  - BUSY: one shift-add (MULU) or restoring shift-subtract (DIVU) step per cycle for WIDTH cycles. On the final step, write aluRes/aluResHi, set outValid, go to IDLE. outValid therefore rises WIDTH+1 edges after acceptance. inReady = 0 throughout.
- Result hold: the output registers (aluRes, aluResHi, zero, overflow, divZero) stay stable while outValid && !outReady. outValid clears on an edge with outReady and no new completion.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs agree (ADD) or differ (SUB) and result sign differs from input1.
  - Shifts use input2[SHAMT_W-1:0]. SRA replicates input1 MSB.
  - SLT/SLTU return 1 or 0 in the LSB.
  - MULU gives the full 2*WIDTH product: {aluResHi, aluRes}.
- DIVU by zero: no iteration; result at latency 1 with aluRes = all ones, aluResHi = input1, divZero = 1.
- Reset (async, any state, including mid-BUSY): state = IDLE, outValid = 0, all result outputs and flags = 0, counter = 0. Any partial mul/div is discarded. inReady = 1 from the first edge after deassertion.
- inValid deasserted: no state change. Operands are ignored unless accepted.

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (ALU_AND … ALU_NOR, ALU_MULU, ALU_DIVU) and FSM state encodings (IDLE, BUSY), so the control unit and this block share one definition.
- One sub-module, alu_mdu_iter: the iterative multiply/divide datapath. Interface: start, op, operands, done, hi/lo.
- The single-cycle combinational ALU and the handshake/FSM stay in alu_seq.

Test Plan:
- Basic ops (WIDTH=32): AND 255,170 -> aluRes=170 one cycle after accept. OR -> 255. SUB 1,1 -> 0 with zero=1. NOR 0,1 -> 0xFFFFFFFE.
- Compare and overflow: SLT 0x80000000,1 -> 1; SLTU same operands -> 0. ADD 0x7FFFFFFF,1 -> 0x80000000 with overflow=1. SRA 0x80000000 by 4 -> 0xF8000000.
- Iterative ops: MULU 0xFFFFFFFF,2 -> hi=1, lo=0xFFFFFFFE, outValid exactly 33 edges after accept with inReady=0 meanwhile. DIVU 100,7 -> q=14, r=2. DIVU 5,0 -> q=0xFFFFFFFF, r=5, divZero=1 at latency 1.
- Backpressure: hold outReady=0 for 5 cycles after a result -> outputs stable, inReady=0. Then outReady=1 with inValid=1 (ADD 2,3) -> new result 5 on the next cycle, no bubble.
- Reset mid-MULU: deassert reset_n 10 cycles into BUSY -> outValid=0 and outputs=0 immediately (async). After release, a new AND completes normally.
- Back-to-back stream: 8 single-cycle ops with outReady held at 1 -> 8 results on 8 consecutive cycles, in order.
